// File: rtl/alu_pkg.sv
// Shared encodings for the serial ALU: operation codes and sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_NOR = 4'b0111,
    ALU_SLT = 4'b1000
  } aluop_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_NOR, ALU_SLT: op_is_legal = 1'b1;
      default:                   op_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_subtracts(input logic [3:0] op);
    op_subtracts = (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit combinational ALU slice; carry only propagates for ADD/SUB/SLT.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] op,
  output logic       r,
  output logic       cout
);

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (op)
      ALU_ADD:          {cout, r} = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      ALU_SUB, ALU_SLT: {cout, r} = {1'b0, a} + {1'b0, ~b} + {1'b0, cin};
      ALU_AND:          r = a & b;
      ALU_OR:           r = a | b;
      ALU_XOR:          r = a ^ b;
      ALU_NOR:          r = ~(a | b);
      default:          r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one bit per RUN cycle, LSB first, result and flags published in FIN.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-2:0] sr;
  logic [3:0]       op;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             s_r;
  logic             s_cout;
  logic [WIDTH-1:0] word;
  logic             ovf;
  logic [WIDTH-1:0] fin_res;
  logic             fin_ovf;
  logic             fin_ill;

  alu_bit_slice u_slice (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .op   (op),
    .r    (s_r),
    .cout (s_cout)
  );

  // Operands shift right so the slice always sees bit 0; the new bit enters the
  // top of the result word, leaving it LSB-aligned after the final bit.
  always_comb begin
    word    = {s_r, sr};
    ovf     = carry ^ s_cout;
    fin_res = '0;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR: fin_res = word;
      ALU_SLT: fin_res[0] = s_r ^ ovf;
      default: fin_res = '0;
    endcase
    fin_ovf = ((op == ALU_ADD) || (op == ALU_SUB)) && ovf;
    fin_ill = !op_is_legal(op);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      opa      <= '0;
      opb      <= '0;
      sr       <= '0;
      op       <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            op    <= aluop;
            cnt   <= '0;
            sr    <= '0;
            carry <= op_subtracts(aluop);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          sr    <= word[WIDTH-1:1];
          carry <= s_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Visible outputs change only here, so they stay stable across the next run.
            result   <= fin_res;
            zero     <= (fin_res == '0);
            overflow <= fin_ovf;
            illegal  <= fin_ill;
            state    <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

endmodule
